jt10_adpcma_enc: RTL and testbench

- Single-channel ADPCM-A (YM2610) encoder: 16-bit signed PCM in, packed 4-bit ADPCM nibbles out, two per byte, high nibble first.
- Inverse of the ADPCM-A decode path. Its internal predictor must track the channel decoder bit-exactly, so encoded ROM images replay identically.
- Used to build sample ROMs in-fabric and as a verification source for the ADPCM-A driver.

---
 rtl/jt10_adpcma_enc_if.sv | 22 ++
 rtl/jt10_adpcma_enc.sv | 203 ++++++++++++++++++++
 tb/tb_jt10_adpcma_enc.sv | 379 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt10_adpcma_enc_if.sv
// Stream interface for the ADPCM-A encoder.
// Carries the PCM sample handshake, the flush request and the packed-byte handshake.
// master: sample producer / byte consumer.  slave: the encoder.
interface jt10_adpcma_enc_if;
  logic [15:0] pcm_in;
  logic        pcm_valid;
  logic        pcm_ready;
  logic        flush;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;

  modport master (
    output pcm_in, pcm_valid, flush, dout_ready,
    input  pcm_ready, dout, dout_valid
  );

  modport slave (
    input  pcm_in, pcm_valid, flush, dout_ready,
    output pcm_ready, dout, dout_valid
  );
endinterface

// File: rtl/jt10_adpcma_enc.sv
// Single-channel ADPCM-A (YM2610) encoder.
// Each accepted 16-bit PCM sample (pcm_in[15:4] used) yields one 4-bit nibble
// {sign, mag} found by a 3-step successive approximation against the current
// step size; the internal predictor is updated exactly as the channel decoder
// would, so the emitted stream replays bit-exactly. Nibbles are packed two per
// byte, high nibble first.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   cen            clock enable, all state advances only when high
//   clr            synchronous predictor clear (leaves a presented byte alone)
//   bus            sample / flush / byte stream (slave side)
//   busy           sample in flight or half byte pending
//   acc            reconstructed 12-bit signed predictor
//   step_idx       step table index 0..48
//   byte_cnt       bytes emitted since reset/clr, saturating
module jt10_adpcma_enc #(
  parameter int unsigned CNTW = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic                clr,
  jt10_adpcma_enc_if.slave    bus,
  output logic                busy,
  output logic [11:0]         acc,
  output logic [5:0]          step_idx,
  output logic [CNTW-1:0]     byte_cnt
);

  typedef enum logic [2:0] {IDLE, SAR2, SAR1, SAR0, UPD} state_t;

  state_t       state;
  logic         started;
  logic         half;
  logic [3:0]   hi;
  logic [7:0]   dout_r;
  logic         dout_valid_r;
  logic         sign;
  logic [2:0]   mag;
  logic [12:0]  rem;

  // Step size for the current index.
  function automatic logic [10:0] step_of(input logic [5:0] i);
    case (i)
      6'd0:  return 11'd16;   6'd1:  return 11'd17;   6'd2:  return 11'd19;   6'd3:  return 11'd21;
      6'd4:  return 11'd23;   6'd5:  return 11'd25;   6'd6:  return 11'd28;   6'd7:  return 11'd31;
      6'd8:  return 11'd34;   6'd9:  return 11'd37;   6'd10: return 11'd41;   6'd11: return 11'd45;
      6'd12: return 11'd50;   6'd13: return 11'd55;   6'd14: return 11'd60;   6'd15: return 11'd66;
      6'd16: return 11'd73;   6'd17: return 11'd80;   6'd18: return 11'd88;   6'd19: return 11'd97;
      6'd20: return 11'd107;  6'd21: return 11'd118;  6'd22: return 11'd130;  6'd23: return 11'd143;
      6'd24: return 11'd157;  6'd25: return 11'd173;  6'd26: return 11'd190;  6'd27: return 11'd209;
      6'd28: return 11'd230;  6'd29: return 11'd253;  6'd30: return 11'd279;  6'd31: return 11'd307;
      6'd32: return 11'd337;  6'd33: return 11'd371;  6'd34: return 11'd408;  6'd35: return 11'd449;
      6'd36: return 11'd494;  6'd37: return 11'd544;  6'd38: return 11'd598;  6'd39: return 11'd658;
      6'd40: return 11'd724;  6'd41: return 11'd796;  6'd42: return 11'd876;  6'd43: return 11'd963;
      6'd44: return 11'd1060; 6'd45: return 11'd1166; 6'd46: return 11'd1282; 6'd47: return 11'd1411;
      default: return 11'd1552;
    endcase
  endfunction

  // Decoder reconstruction: acc +/- ((2*mag+1)*step)>>3, in 14 bits to expose overflow.
  function automatic logic signed [13:0] recon(input logic [11:0] a, input logic s,
                                               input logic [2:0] m, input logic [10:0] st);
    logic [14:0]        prod;
    logic signed [13:0] base;
    logic signed [13:0] diff;
    prod = 15'({m, 1'b1}) * 15'(st);
    base = $signed({{2{a[11]}}, a});
    diff = $signed({2'b00, prod[14:3]});
    return s ? (base - diff) : (base + diff);
  endfunction

  logic [10:0]        step;
  logic [12:0]        step13;
  logic signed [12:0] delta_c;
  logic               pcm_ready_c;
  logic               accept;
  logic [CNTW-1:0]    cnt_inc;

  assign step        = step_of(step_idx);
  assign step13      = {2'b00, step};
  assign delta_c     = $signed({bus.pcm_in[15], bus.pcm_in[15:4]}) - $signed({acc[11], acc});
  assign pcm_ready_c = started && (state == IDLE) && !dout_valid_r && !clr;
  assign accept      = bus.pcm_valid && pcm_ready_c;
  assign cnt_inc     = (&byte_cnt) ? byte_cnt : byte_cnt + CNTW'(1);

  assign bus.pcm_ready  = pcm_ready_c;
  assign bus.dout       = dout_r;
  assign bus.dout_valid = dout_valid_r;
  assign busy           = (state != IDLE) || half;

  // Overflow handling: shrink mag until the predictor stays in range, then flip sign.
  logic [2:0]         upd_mag;
  logic               upd_sign;
  logic signed [13:0] upd_new;
  logic signed [7:0]  adj;
  logic signed [7:0]  nidx;
  logic [5:0]         upd_idx;

  always_comb begin
    upd_mag  = mag;
    upd_sign = sign;
    upd_new  = recon(acc, upd_sign, upd_mag, step);
    for (int i = 0; i < 8; i++) begin
      if ((upd_new > 14'sd2047) || (upd_new < -14'sd2048)) begin
        if (upd_mag != 3'd0) upd_mag = upd_mag - 3'd1;
        else                 upd_sign = ~upd_sign;
        upd_new = recon(acc, upd_sign, upd_mag, step);
      end
    end
    case (upd_mag)
      3'd4:    adj = 8'sd2;
      3'd5:    adj = 8'sd5;
      3'd6:    adj = 8'sd7;
      3'd7:    adj = 8'sd9;
      default: adj = -8'sd1;
    endcase
    nidx = $signed({2'b00, step_idx}) + adj;
    if (nidx < 8'sd0)       upd_idx = 6'd0;
    else if (nidx > 8'sd48) upd_idx = 6'd48;
    else                    upd_idx = nidx[5:0];
  end

  // Encoder FSM, packing and byte handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      started      <= 1'b0;
      acc          <= 12'd0;
      step_idx     <= 6'd0;
      byte_cnt     <= '0;
      half         <= 1'b0;
      hi           <= 4'd0;
      dout_r       <= 8'd0;
      dout_valid_r <= 1'b0;
      sign         <= 1'b0;
      mag          <= 3'd0;
      rem          <= 13'd0;
    end else begin
      started <= 1'b1;
      if (cen) begin
        if (dout_valid_r && bus.dout_ready) dout_valid_r <= 1'b0;
        if (clr) begin
          acc      <= 12'd0;
          step_idx <= 6'd0;
          state    <= IDLE;
          half     <= 1'b0;
          byte_cnt <= '0;
        end else begin
          case (state)
            IDLE: begin
              if (accept) begin
                sign  <= delta_c[12];
                rem   <= delta_c[12] ? 13'(-delta_c) : 13'(delta_c);
                mag   <= 3'd0;
                state <= SAR2;
              end else if (bus.flush && half && !dout_valid_r) begin
                dout_r       <= {hi, 4'h0};
                dout_valid_r <= 1'b1;
                half         <= 1'b0;
                byte_cnt     <= cnt_inc;
              end
            end
            SAR2: begin
              if (rem >= step13) begin
                mag[2] <= 1'b1;
                rem    <= rem - step13;
              end
              state <= SAR1;
            end
            SAR1: begin
              if (rem >= {3'b000, step[10:1]}) begin
                mag[1] <= 1'b1;
                rem    <= rem - {3'b000, step[10:1]};
              end
              state <= SAR0;
            end
            SAR0: begin
              if (rem >= {4'b0000, step[10:2]}) mag[0] <= 1'b1;
              state <= UPD;
            end
            UPD: begin
              acc      <= upd_new[11:0];
              step_idx <= upd_idx;
              if (!half) begin
                hi   <= {upd_sign, upd_mag};
                half <= 1'b1;
              end else begin
                dout_r       <= {hi, upd_sign, upd_mag};
                dout_valid_r <= 1'b1;
                half         <= 1'b0;
                byte_cnt     <= cnt_inc;
              end
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_jt10_adpcma_enc.sv
// Self-checking bench for jt10_adpcma_enc: a software encoder/decoder model
// predicts each nibble and predictor value; expected bytes are queued when a
// sample is accepted and compared when the encoder presents a byte.
module tb_jt10_adpcma_enc;

  logic        clk;
  logic        rst_n;
  logic        cen;
  logic        clr;
  logic        busy;
  logic [11:0] acc;
  logic [5:0]  step_idx;
  logic [19:0] byte_cnt;

  jt10_adpcma_enc_if ifc ();

  jt10_adpcma_enc #(.CNTW(20)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .clr      (clr),
    .bus      (ifc),
    .busy     (busy),
    .acc      (acc),
    .step_idx (step_idx),
    .byte_cnt (byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int steps [0:48] = '{16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,
                       107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,
                       494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552};

  // Reference model state
  int         m_acc;
  int         m_idx;
  bit         m_half;
  logic [3:0] m_hi;
  int         m_cnt;
  logic [7:0] exp_q [$];

  task automatic model_reset();
    m_acc = 0; m_idx = 0; m_half = 0; m_hi = 4'd0; m_cnt = 0;
  endtask

  // Encode one sample the way the hardware must, then decode it as the YM2610 would.
  task automatic model_step(input logic [15:0] pcm);
    int t, d, s, r, st, m, diff, nv, n;
    logic [3:0] nib;
    bit done;
    t  = int'($signed(pcm[15:4]));
    d  = t - m_acc;
    s  = (d < 0) ? 1 : 0;
    r  = (s != 0) ? -d : d;
    st = steps[m_idx];
    m  = 0;
    if (r >= st)     begin m += 4; r -= st; end
    if (r >= st / 2) begin m += 2; r -= st / 2; end
    if (r >= st / 4) m += 1;
    done = 0; n = 0; nv = 0;
    while (!done) begin
      diff = ((2 * m + 1) * st) / 8;
      nv   = (s != 0) ? m_acc - diff : m_acc + diff;
      if ((nv >= -2048 && nv <= 2047) || n > 16) done = 1;
      else begin
        if (m > 0) m--; else s = 1 - s;
        n++;
      end
    end
    m_acc = nv;
    case (m)
      4: m_idx += 2;
      5: m_idx += 5;
      6: m_idx += 7;
      7: m_idx += 9;
      default: m_idx -= 1;
    endcase
    if (m_idx < 0)  m_idx = 0;
    if (m_idx > 48) m_idx = 48;
    nib = {s[0], m[2:0]};
    if (m_half) begin
      exp_q.push_back({m_hi, nib});
      m_half = 0;
      m_cnt++;
    end else begin
      m_hi   = nib;
      m_half = 1;
    end
  endtask

  task automatic model_flush();
    if (m_half) begin
      exp_q.push_back({m_hi, 4'h0});
      m_half = 0;
      m_cnt++;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cen = 1'b1; clr = 1'b0;
    ifc.pcm_in = 16'h0; ifc.pcm_valid = 1'b0; ifc.flush = 1'b0; ifc.dout_ready = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offer a sample until accepted (bounded), then wait until its UPD has taken effect.
  task automatic send_sample(input logic [15:0] pcm, output bit ok);
    int n = 0;
    ifc.pcm_in = pcm;
    ifc.pcm_valid = 1'b1;
    while (!ifc.pcm_ready && n < 50) begin @(negedge clk); n++; end
    ok = ifc.pcm_ready;
    @(negedge clk);
    ifc.pcm_valid = 1'b0;
    if (ok) begin
      model_step(pcm);
      repeat (4) @(negedge clk);
    end
  endtask

  // Wait (bounded) for a byte and take it with a one-cycle dout_ready pulse.
  task automatic pop_byte(output logic [7:0] got, output bit ok);
    int n = 0;
    while (!ifc.dout_valid && n < 20) begin @(negedge clk); n++; end
    ok  = ifc.dout_valid;
    got = ifc.dout;
    if (ok) begin
      ifc.dout_ready = 1'b1;
      @(negedge clk);
      ifc.dout_ready = 1'b0;
    end
  endtask

  function automatic logic [7:0] next_exp();
    if (exp_q.size() != 0) return exp_q.pop_front();
    return 8'hxx;
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (ifc.pcm_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready0 got=%b want=0", ifc.pcm_ready); end
    n_cmp++;
    if ({ifc.dout, ifc.dout_valid, busy, acc, step_idx, byte_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_state dout=%h dv=%b busy=%b acc=%0d idx=%0d cnt=%0d want all 0",
               ifc.dout, ifc.dout_valid, busy, acc, step_idx, byte_cnt);
    end
    @(negedge clk);
    n_cmp++;
    if (ifc.pcm_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready1 got=%b want=1", ifc.pcm_ready); end
  endtask

  task automatic test_basic();
    bit ok; logic [7:0] got, ex;
    do_reset();
    @(negedge clk);
    send_sample(16'h0100, ok);
    n_cmp++;
    if (!ok || acc !== 12'd18 || step_idx !== 6'd2 || busy !== 1'b1 || ifc.dout_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_first ok=%0d acc=%0d idx=%0d busy=%b dv=%b want acc=18 idx=2 busy=1 dv=0",
               ok, $signed(acc), step_idx, busy, ifc.dout_valid);
    end
    send_sample(16'h0100, ok);
    n_cmp++;
    if (!ok || acc !== 12'd16 || step_idx !== 6'd1 || byte_cnt !== 20'd1) begin
      n_bad++;
      $display("FAIL basic_second ok=%0d acc=%0d idx=%0d cnt=%0d want acc=16 idx=1 cnt=1",
               ok, $signed(acc), step_idx, byte_cnt);
    end
    pop_byte(got, ok);
    ex = next_exp();
    n_cmp++;
    if (!ok || got !== ex || got !== 8'h48) begin
      n_bad++; $display("FAIL basic_byte ok=%0d got=%h want=%h (48)", ok, got, ex);
    end
  endtask

  task automatic test_flush();
    bit ok; logic [7:0] got, ex;
    do_reset();
    @(negedge clk);
    send_sample(16'h0100, ok);
    ifc.flush = 1'b1;
    model_flush();
    @(negedge clk);
    ifc.flush = 1'b0;
    n_cmp++;
    if (!ok || ifc.dout_valid !== 1'b1 || byte_cnt !== 20'd1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_emit ok=%0d dv=%b cnt=%0d busy=%b want dv=1 cnt=1 busy=0",
               ok, ifc.dout_valid, byte_cnt, busy);
    end
    pop_byte(got, ok);
    ex = next_exp();
    n_cmp++;
    if (!ok || got !== ex || got !== 8'h40) begin
      n_bad++; $display("FAIL flush_byte ok=%0d got=%h want=%h (40)", ok, got, ex);
    end
    ifc.flush = 1'b1;
    repeat (4) @(negedge clk);
    ifc.flush = 1'b0;
    n_cmp++;
    if (ifc.dout_valid !== 1'b0 || byte_cnt !== 20'd1) begin
      n_bad++; $display("FAIL flush_second dv=%b cnt=%0d want dv=0 cnt=1", ifc.dout_valid, byte_cnt);
    end
  endtask

  task automatic test_saturate();
    bit ok; logic [7:0] got, ex;
    int bad = 0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      send_sample(16'h7FF0, ok);
      n_cmp++;
      if (!ok || int'($signed(acc)) !== m_acc || int'(step_idx) !== m_idx) begin
        n_bad++; bad++;
        if (bad < 5) $display("FAIL sat_acc[%0d] ok=%0d acc=%0d idx=%0d want acc=%0d idx=%0d",
                              i, ok, $signed(acc), step_idx, m_acc, m_idx);
      end
      if (ifc.dout_valid) begin
        pop_byte(got, ok);
        ex = next_exp();
        n_cmp++;
        if (got !== ex) begin n_bad++; $display("FAIL sat_byte[%0d] got=%h want=%h", i, got, ex); end
      end
    end
    n_cmp++;
    if (byte_cnt !== 20'(m_cnt) || m_cnt != 32) begin
      n_bad++; $display("FAIL sat_cnt got=%0d want=32", byte_cnt);
    end
  endtask

  task automatic test_alternate();
    bit ok; logic [7:0] got, ex;
    int bad = 0;
    int peak_dut = 0, peak_mod = 0;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 100; i++) begin
      send_sample((i % 2 == 0) ? 16'h8000 : 16'h7FF0, ok);
      if (int'(step_idx) > peak_dut) peak_dut = int'(step_idx);
      if (m_idx > peak_mod) peak_mod = m_idx;
      n_cmp++;
      if (!ok || int'($signed(acc)) !== m_acc || int'(step_idx) !== m_idx) begin
        n_bad++; bad++;
        if (bad < 5) $display("FAIL alt_acc[%0d] ok=%0d acc=%0d idx=%0d want acc=%0d idx=%0d",
                              i, ok, $signed(acc), step_idx, m_acc, m_idx);
      end
      if (ifc.dout_valid) begin
        pop_byte(got, ok);
        ex = next_exp();
        n_cmp++;
        if (got !== ex) begin n_bad++; $display("FAIL alt_byte[%0d] got=%h want=%h", i, got, ex); end
      end
    end
    n_cmp++;
    if (peak_dut !== peak_mod || peak_dut > 48) begin
      n_bad++; $display("FAIL alt_peak_idx got=%0d want=%0d", peak_dut, peak_mod);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; logic [7:0] got, ex;
    int held = 0;
    do_reset();
    @(negedge clk);
    send_sample(16'h0100, ok);
    send_sample(16'h0100, ok);
    ifc.pcm_in = 16'h0800;
    ifc.pcm_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifc.pcm_ready !== 1'b0 || ifc.dout_valid !== 1'b1) held++;
    end
    n_cmp++;
    if (held != 0 || byte_cnt !== 20'd1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL bp_hold bad_cycles=%0d cnt=%0d busy=%b want 0/1/0", held, byte_cnt, busy);
    end
    pop_byte(got, ok);
    ex = next_exp();
    n_cmp++;
    if (!ok || got !== ex || byte_cnt !== 20'd1) begin
      n_bad++; $display("FAIL bp_byte1 ok=%0d got=%h want=%h cnt=%0d want 1", ok, got, ex, byte_cnt);
    end
    send_sample(16'h0800, ok);
    send_sample(16'hF000, ok);
    pop_byte(got, ok);
    ex = next_exp();
    n_cmp++;
    if (!ok || got !== ex || byte_cnt !== 20'd2 || int'($signed(acc)) !== m_acc) begin
      n_bad++;
      $display("FAIL bp_byte2 ok=%0d got=%h want=%h cnt=%0d want 2 acc=%0d want %0d",
               ok, got, ex, byte_cnt, $signed(acc), m_acc);
    end
  endtask

  task automatic test_clr();
    bit ok; logic [7:0] got, ex;
    int n = 0;
    do_reset();
    @(negedge clk);
    send_sample(16'h0100, ok);
    ifc.pcm_in = 16'h0400;
    ifc.pcm_valid = 1'b1;
    while (!ifc.pcm_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);                 // accepted, now in SAR2
    ifc.pcm_valid = 1'b0;
    @(negedge clk);                 // now in SAR1
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_reset();
    exp_q.delete();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (acc !== 12'd0 || step_idx !== 6'd0 || byte_cnt !== 20'd0 || ifc.dout_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_state acc=%0d idx=%0d cnt=%0d dv=%b busy=%b want all 0",
               $signed(acc), step_idx, byte_cnt, ifc.dout_valid, busy);
    end
    send_sample(16'h0100, ok);
    send_sample(16'h0100, ok);
    pop_byte(got, ok);
    ex = next_exp();
    n_cmp++;
    if (!ok || got !== ex || got !== 8'h48 || acc !== 12'd16 || byte_cnt !== 20'd1) begin
      n_bad++;
      $display("FAIL clr_after ok=%0d got=%h want=%h acc=%0d want 16 cnt=%0d want 1",
               ok, got, ex, $signed(acc), byte_cnt);
    end
  endtask

  task automatic test_cen_freeze();
    bit ok;
    do_reset();
    @(negedge clk);
    send_sample(16'h0100, ok);
    cen = 1'b0;
    ifc.pcm_in = 16'h7FF0;
    ifc.pcm_valid = 1'b1;
    ifc.flush = 1'b1;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (acc !== 12'd18 || step_idx !== 6'd2 || ifc.dout_valid !== 1'b0 || busy !== 1'b1 || byte_cnt !== 20'd0) begin
      n_bad++;
      $display("FAIL cen_freeze acc=%0d idx=%0d dv=%b busy=%b cnt=%0d want 18/2/0/1/0",
               $signed(acc), step_idx, ifc.dout_valid, busy, byte_cnt);
    end
    ifc.pcm_valid = 1'b0;
    ifc.flush = 1'b0;
    cen = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flush();
    test_saturate();
    test_alternate();
    test_back_to_back();
    test_clr();
    test_cen_freeze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
